avalon_mem_arbiter: RTL and testbench

// - Shares one single-port, fixed-latency-1 Avalon memory slave (boot ROM / on-chip RAM) between two masters.
// - Master 0 is instruction fetch and master 1 is the data port.
// - Round-robin arbitration with grant locking while the slave stalls; read data is routed back to the issuing master.
// - Sits between the CPU bus masters and the memory's slave select/decode.

---
 rtl/bus_pkg.sv | 15 +
 rtl/avalon_mem_arbiter_rr_arbiter2.sv | 58 +++++
 rtl/avalon_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_avalon_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus constants for the CPU memory-side interconnect: arbiter FSM states,
// master indices and the word-address width helper.
package bus_pkg;

   localparam logic ARB  = 1'b0;
   localparam logic HOLD = 1'b1;

   localparam logic M_IFETCH = 1'b0;
   localparam logic M_DATA   = 1'b1;

   function automatic int addr_w(input int sel_bits);
      return 30 - sel_bits;
   endfunction

endpackage

// File: rtl/avalon_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select. The pointer remembers the last accepted
// master; a locked grant overrides arbitration while the slave stalls.
module rr_arbiter2 import bus_pkg::*; #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  logic       lock_idx_i,
   input  logic       advance_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   logic last_q;

   // Winner select; a locked grant is only valid while its master still requests
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = M_IFETCH;
      if (lock_i) begin
         gnt_idx_o = lock_idx_i;
         gnt_vld_o = req_i[lock_idx_i];
      end else begin
         case (req_i)
            2'b01: begin
               gnt_vld_o = 1'b1;
               gnt_idx_o = M_IFETCH;
            end
            2'b10: begin
               gnt_vld_o = 1'b1;
               gnt_idx_o = M_DATA;
            end
            2'b11: begin
               gnt_vld_o = 1'b1;
               gnt_idx_o = FIXED_PRIO ? M_IFETCH : ~last_q;
            end
            default: begin
               gnt_vld_o = 1'b0;
               gnt_idx_o = M_IFETCH;
            end
         endcase
      end
   end

   // Last-grant pointer starts at M_DATA so instruction fetch wins first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= M_DATA;
      end else if (advance_i) begin
         last_q <= gnt_idx_o;
      end else begin
         last_q <= last_q;
      end
   end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares a single latency-1 Avalon memory slave between instruction fetch (M0)
// and the data port (M1); routes read data back to the issuing master.
module avalon_mem_arbiter import bus_pkg::*; #(
   parameter int ADDR_SEL_BITS = 6,
   parameter bit FIXED_PRIO    = 1'b0,
   localparam int AW           = addr_w(ADDR_SEL_BITS)
) (
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_M0_Read,
   input  logic [AW-1:0] i_M0_RegAddr,
   output logic [31:0]   o_M0_ReadData,
   output logic          o_M0_WaitRequest,
   input  logic          i_M1_Read,
   input  logic          i_M1_Write,
   input  logic [AW-1:0] i_M1_RegAddr,
   input  logic [31:0]   i_M1_WriteData,
   input  logic [3:0]    i_M1_ByteEnable,
   output logic [31:0]   o_M1_ReadData,
   output logic          o_M1_WaitRequest,
   output logic          o_S_SlaveSel,
   output logic [AW-1:0] o_S_RegAddr,
   output logic          o_S_Read,
   output logic          o_S_Write,
   output logic [31:0]   o_S_WriteData,
   output logic [3:0]    o_S_ByteEnable,
   input  logic [31:0]   i_S_ReadData,
   input  logic          i_S_WaitRequest
);

   logic       state_q, state_d;
   logic       lock_q, lock_d;
   logic       tag_vld_q, tag_vld_d;
   logic       tag_m_q, tag_m_d;
   logic [1:0] req_s;
   logic       gnt_vld_s, gnt_idx_s;
   logic       drive_s, accept_s;

   assign req_s    = {i_M1_Read | i_M1_Write, i_M0_Read};
   assign drive_s  = gnt_vld_s & ~i_Reset;
   assign accept_s = drive_s & ~i_S_WaitRequest;

   rr_arbiter2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_rr (
      .clk_i     (i_Clk),
      .rst_i     (i_Reset),
      .req_i     (req_s),
      .lock_i    (state_q == HOLD),
      .lock_idx_i(lock_q),
      .advance_i (accept_s),
      .gnt_vld_o (gnt_vld_s),
      .gnt_idx_o (gnt_idx_s)
   );

   // Slave-side mux; a simultaneous read and write from M1 is issued as a read
   always_comb begin
      o_S_SlaveSel   = 1'b0;
      o_S_RegAddr    = '0;
      o_S_Read       = 1'b0;
      o_S_Write      = 1'b0;
      o_S_WriteData  = 32'h0000_0000;
      o_S_ByteEnable = 4'b0000;
      if (drive_s) begin
         o_S_SlaveSel = 1'b1;
         if (gnt_idx_s == M_DATA) begin
            o_S_RegAddr    = i_M1_RegAddr;
            o_S_Read       = i_M1_Read;
            o_S_Write      = i_M1_Write & ~i_M1_Read;
            o_S_WriteData  = (i_M1_Write & ~i_M1_Read) ? i_M1_WriteData : 32'h0000_0000;
            o_S_ByteEnable = i_M1_ByteEnable;
         end else begin
            o_S_RegAddr    = i_M0_RegAddr;
            o_S_Read       = 1'b1;
            o_S_ByteEnable = 4'b1111;
         end
      end else begin
         o_S_SlaveSel = 1'b0;
      end
   end

   assign o_M0_WaitRequest = req_s[0] & ~(accept_s & (gnt_idx_s == M_IFETCH));
   assign o_M1_WaitRequest = req_s[1] & ~(accept_s & (gnt_idx_s == M_DATA));

   assign o_M0_ReadData = (~i_Reset & tag_vld_q & (tag_m_q == M_IFETCH)) ? i_S_ReadData : 32'h0000_0000;
   assign o_M1_ReadData = (~i_Reset & tag_vld_q & (tag_m_q == M_DATA))   ? i_S_ReadData : 32'h0000_0000;

   // Grant-lock FSM and one-cycle read-return tag
   always_comb begin
      state_d   = state_q;
      lock_d    = lock_q;
      tag_vld_d = accept_s & o_S_Read;
      tag_m_d   = gnt_idx_s;
      case (state_q)
         ARB: begin
            if (drive_s & i_S_WaitRequest) begin
               state_d = HOLD;
               lock_d  = gnt_idx_s;
            end else begin
               state_d = ARB;
            end
         end
         HOLD: begin
            // A dropped locked request releases the lock without an accept
            if (~gnt_vld_s | accept_s) begin
               state_d = ARB;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= ARB;
         lock_q    <= M_IFETCH;
         tag_vld_q <= 1'b0;
         tag_m_q   <= M_IFETCH;
      end else begin
         state_q   <= state_d;
         lock_q    <= lock_d;
         tag_vld_q <= tag_vld_d;
         tag_m_q   <= tag_m_d;
      end
   end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Randomized bench for avalon_mem_arbiter against a cycle-level reference of
// the arbitration, locking and read-return rules, plus a fixed-priority instance.
module tb_avalon_mem_arbiter;

   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_rd, m1_rd, m1_wr, s_wait;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [31:0]   m1_wdata;
   logic [3:0]    m1_be;
   logic [31:0]   m0_rdata, m1_rdata, s_rdata;
   logic          m0_wait, m1_wait;
   logic          s_sel, s_read, s_write;
   logic [AW-1:0] s_addr;
   logic [31:0]   s_wdata;
   logic [3:0]    s_be;

   logic [31:0]   fx_m0_rdata, fx_m1_rdata, fx_wdata, zero_data;
   logic          fx_m0_wait, fx_m1_wait, fx_sel, fx_read, fx_write;
   logic [AW-1:0] fx_addr;
   logic [3:0]    fx_be;

   logic [31:0]   mem     [64];
   logic [31:0]   ref_mem [64];

   int            last_g, locked, ret_m;
   logic [31:0]   ret_data;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   avalon_mem_arbiter #(.ADDR_SEL_BITS(6), .FIXED_PRIO(1'b0)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_M0_Read(m0_rd), .i_M0_RegAddr(m0_addr),
      .o_M0_ReadData(m0_rdata), .o_M0_WaitRequest(m0_wait),
      .i_M1_Read(m1_rd), .i_M1_Write(m1_wr), .i_M1_RegAddr(m1_addr),
      .i_M1_WriteData(m1_wdata), .i_M1_ByteEnable(m1_be),
      .o_M1_ReadData(m1_rdata), .o_M1_WaitRequest(m1_wait),
      .o_S_SlaveSel(s_sel), .o_S_RegAddr(s_addr), .o_S_Read(s_read),
      .o_S_Write(s_write), .o_S_WriteData(s_wdata), .o_S_ByteEnable(s_be),
      .i_S_ReadData(s_rdata), .i_S_WaitRequest(s_wait)
   );

   avalon_mem_arbiter #(.ADDR_SEL_BITS(6), .FIXED_PRIO(1'b1)) dut_fx (
      .i_Clk(clk), .i_Reset(rst),
      .i_M0_Read(m0_rd), .i_M0_RegAddr(m0_addr),
      .o_M0_ReadData(fx_m0_rdata), .o_M0_WaitRequest(fx_m0_wait),
      .i_M1_Read(m1_rd), .i_M1_Write(m1_wr), .i_M1_RegAddr(m1_addr),
      .i_M1_WriteData(m1_wdata), .i_M1_ByteEnable(m1_be),
      .o_M1_ReadData(fx_m1_rdata), .o_M1_WaitRequest(fx_m1_wait),
      .o_S_SlaveSel(fx_sel), .o_S_RegAddr(fx_addr), .o_S_Read(fx_read),
      .o_S_Write(fx_write), .o_S_WriteData(fx_wdata), .o_S_ByteEnable(fx_be),
      .i_S_ReadData(zero_data), .i_S_WaitRequest(s_wait)
   );

   // Latency-1 memory slave driven by the main instance
   always @(posedge clk) begin
      if (s_sel && !s_wait) begin
         if (s_read) begin
            s_rdata <= mem[s_addr[5:0]];
         end else if (s_write) begin
            for (int b = 0; b < 4; b++) begin
               if (s_be[b]) mem[s_addr[5:0]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle: apply inputs, compare at negedge, advance the reference
   task automatic step(input logic r, input logic r0, input logic r1, input logic w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic sw, input logic chk_fx);
      int win, fwin;
      logic q0, q1, acc, e_rd, e_wr;
      logic [AW-1:0] e_addr;
      rst = r; m0_rd = r0; m1_rd = r1; m1_wr = w1; m0_addr = a0; m1_addr = a1;
      m1_wdata = wd; m1_be = be; s_wait = sw;
      @(negedge clk);
      q0 = r0;
      q1 = r1 | w1;
      if (r) begin
         check("rst_sel", s_sel, 1'b0);
         check("rst_strobes", {s_read, s_write, s_be, s_wdata, s_addr}, '0);
         check("rst_wait0", m0_wait, q0);
         check("rst_wait1", m1_wait, q1);
         check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
         last_g = 1; locked = -1; ret_m = -1;
      end else begin
         if (locked >= 0)      win = ((locked == 0) ? q0 : q1) ? locked : -1;
         else if (q0 && q1)    win = (last_g == 0) ? 1 : 0;
         else if (q0)          win = 0;
         else if (q1)          win = 1;
         else                  win = -1;
         acc    = (win >= 0) && !sw;
         e_addr = (win == 1) ? a1 : a0;
         e_rd   = (win == 1) ? r1 : 1'b1;
         e_wr   = (win == 1) && w1 && !r1;
         check("sel", s_sel, win >= 0);
         if (win >= 0) begin
            check("addr", s_addr, e_addr);
            check("read", s_read, e_rd);
            check("write", s_write, e_wr);
            if (e_wr) check("wdata_be", {s_be, s_wdata}, {be, wd});
         end else begin
            check("idle_bus", {s_read, s_write, s_be, s_wdata, s_addr}, '0);
         end
         check("wait0", m0_wait, q0 && !(acc && win == 0));
         check("wait1", m1_wait, q1 && !(acc && win == 1));
         check("rdata0", m0_rdata, (ret_m == 0) ? ret_data : 32'h0);
         check("rdata1", m1_rdata, (ret_m == 1) ? ret_data : 32'h0);
         if (chk_fx) begin
            fwin = q0 ? 0 : (q1 ? 1 : -1);
            check("fx_wait0", fx_m0_wait, q0 && !(fwin == 0));
            check("fx_wait1", fx_m1_wait, q1 && !(fwin == 1));
         end
         ret_m = -1;
         if (acc) begin
            last_g = win;
            locked = -1;
            if (e_rd) begin
               ret_m    = win;
               ret_data = ref_mem[e_addr[5:0]];
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) ref_mem[e_addr[5:0]][8*b +: 8] = wd[8*b +: 8];
               end
            end
         end else if (win >= 0) begin
            locked = win;
         end else begin
            locked = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      zero_data = 32'h0;
      s_rdata   = 32'h0;
      last_g = 1; locked = -1; ret_m = -1; ret_data = 32'h0;
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
      end
      ref_mem[5] = 32'h0003_2403;
      for (int i = 0; i < 64; i++) mem[i] = ref_mem[i];
      @(posedge clk);
      #1;

      // Reset with M0 requesting, then M0 alone on addr 5
      step(1'b1, 1'b1, 1'b0, 1'b0, 24'd5, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 24'd5, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd5, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      check("m0_addr5_data", m0_rdata, 32'h0);

      // Contention: grants alternate every cycle
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b1, 1'b1, 1'b0, 24'd2, 24'd40, 32'h0, 4'hF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);

      // M1 write locked through a 3-cycle stall, then M0 is served
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 1'b1, 24'd3, 24'd7, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 24'd3, 24'd7, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd3, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 24'd7, 32'h0, 4'hF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);

      // Fixed-priority instance: M0 wins every tie, M1 served when M0 idles
      step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 1'b1, 1'b0, 24'd9, 24'd12, 32'h0, 4'hF, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 24'd12, 32'h0, 4'hF, 1'b0, 1'b1);

      // Reset right after an M1 read accept drops its return data
      step(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 24'd33, 32'h0, 4'hF, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 24'd1, 24'd2, 32'h0, 4'hF, 1'b0, 1'b0);

      // Randomized traffic with stalls, lock drops and occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 35),
              AW'($urandom()), AW'($urandom()), $urandom(), 4'($urandom()),
              ($urandom_range(0, 99) < 30), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
